// File: rtl/regfile_dump_pkg.sv
// Shared types and default widths for the register-file dump block and the cpu register file.
package regfile_dump_pkg;

  localparam int NREGS_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    READ,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_out_reg.sv
// Output holding register for dump streams: captures one {addr, data} beat and
// holds it with valid asserted until the consumer accepts it.
module dump_out_reg #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_addr  <= load_addr;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Halts the cpu, walks every register through a read port and streams {addr, data} beats.
// Optional build macro REGFILE_DUMP_CHECK_EN adds a single-register expected-value check.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              halt_req,
  input  logic              halted,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
`ifdef REGFILE_DUMP_CHECK_EN
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] chk_expect,
  output logic              chk_valid,
  output logic              chk_pass,
`endif
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] index;
  logic              accept;

  assign accept   = out_valid && out_ready;
  assign rf_raddr = (state == READ) ? index : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      index    <= '0;
      halt_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HALT_WAIT;
            index    <= '0;
            halt_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        HALT_WAIT: begin
          if (halted) state <= READ;
        end
        READ: begin
          state <= SEND;
        end
        SEND: begin
          if (accept) begin
            // Terminal compare on NREGS-1 so the counter never has to wrap.
            if (index == LAST_IDX) begin
              state    <= DONE;
              done     <= 1'b1;
              halt_req <= 1'b0;
            end else begin
              index <= index + ADDR_W'(1);
              state <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          halt_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  dump_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (state == READ),
    .load_addr (index),
    .load_data (rf_rdata),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data)
  );

`ifdef REGFILE_DUMP_CHECK_EN
  logic [ADDR_W-1:0] chk_addr_q;
  logic [DATA_W-1:0] chk_expect_q;

  // Check target is latched at start so the host may change the inputs mid-dump.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_addr_q   <= '0;
      chk_expect_q <= '0;
      chk_valid    <= 1'b0;
      chk_pass     <= 1'b0;
    end else if (state == IDLE && start) begin
      chk_addr_q   <= chk_addr;
      chk_expect_q <= chk_expect;
      chk_valid    <= 1'b0;
      chk_pass     <= 1'b0;
    end else if (state == SEND && accept) begin
      if (out_addr == chk_addr_q) chk_pass <= (out_data == chk_expect_q);
      if (index == LAST_IDX) chk_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump with an array model of the cpu register file.
module tb_regfile_dump;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              halt_req;
  logic              halted = 1'b1;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
`ifdef REGFILE_DUMP_CHECK_EN
  logic [ADDR_W-1:0] chk_addr = '0;
  logic [DATA_W-1:0] chk_expect = '0;
  logic              chk_valid;
  logic              chk_pass;
`endif

  logic [DATA_W-1:0] rf [NREGS];
  assign rf_rdata = rf[rf_raddr];

  int total = 0;
  int bad = 0;

  int beat_addr[$];
  logic [DATA_W-1:0] beat_data[$];
  int done_cyc, idle_cyc, stalls, hold_viol, dones;
  bit timed_out;

  always #5 clk = ~clk;

  regfile_dump #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .halt_req  (halt_req),
    .halted    (halted),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
`ifdef REGFILE_DUMP_CHECK_EN
    .chk_addr  (chk_addr),
    .chk_expect(chk_expect),
    .chk_valid (chk_valid),
    .chk_pass  (chk_pass),
`endif
    .done      (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rf();
    for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
    rf[0]  = '0;
    rf[2]  = 270;
    rf[8]  = 119;
    rf[11] = 42;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives out_ready and records accepted beats; mode 0 = always ready, 1 = toggling, 2 = random.
  task automatic run_dump(input int mode, input int limit);
    bit held = 0;
    int h_addr = 0;
    logic [DATA_W-1:0] h_data = '0;
    beat_addr.delete();
    beat_data.delete();
    done_cyc = -1; idle_cyc = -1; stalls = 0; hold_viol = 0; dones = 0;
    timed_out = 1;
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (cyc > 0) begin
        if (held && !(out_valid && int'(out_addr) == h_addr && out_data == h_data)) hold_viol++;
        if (done) begin
          dones++;
          if (done_cyc < 0) done_cyc = cyc;
        end
        if (done_cyc >= 0 && !busy) begin
          idle_cyc = cyc;
          timed_out = 0;
          break;
        end
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 2) == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      held = 0;
      if (out_valid && out_ready) begin
        beat_addr.push_back(int'(out_addr));
        beat_data.push_back(out_data);
      end else if (out_valid) begin
        stalls++;
        held = 1;
        h_addr = int'(out_addr);
        h_data = out_data;
      end
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if ({halt_req, out_valid, busy, done} !== 4'b0000 || out_addr !== '0 || out_data !== '0 || rf_raddr !== '0) begin
      bad++;
      $display("FAIL reset_values: hr=%b ov=%b busy=%b done=%b addr=%0d data=%0d raddr=%0d, all required 0",
               halt_req, out_valid, busy, done, out_addr, out_data, rf_raddr);
    end
  endtask

  task automatic test_full_dump();
    load_rf();
    halted = 1'b1;
    do_start();
    total++;
    if (busy !== 1'b1 || halt_req !== 1'b1) begin
      bad++;
      $display("FAIL start_edge: busy=%b halt_req=%b required 1 1", busy, halt_req);
    end
    run_dump(0, 300);
    total++;
    if (timed_out || beat_addr.size() != NREGS) begin
      bad++;
      $display("FAIL full_count: beats=%0d timeout=%0d required %0d 0", beat_addr.size(), timed_out, NREGS);
    end
    for (int i = 0; i < beat_addr.size() && i < NREGS; i++) begin
      total++;
      if (beat_addr[i] != i || beat_data[i] !== rf[i]) begin
        bad++;
        $display("FAIL full_beat%0d: addr=%0d data=%0d required addr=%0d data=%0d", i, beat_addr[i], beat_data[i], i, rf[i]);
      end
    end
    total++;
    if (done_cyc != 1 + 2 * NREGS || idle_cyc != 2 + 2 * NREGS || dones != 1) begin
      bad++;
      $display("FAIL full_timing: done_at=%0d idle_at=%0d dones=%0d required %0d %0d 1",
               done_cyc, idle_cyc, dones, 1 + 2 * NREGS, 2 + 2 * NREGS);
    end
    total++;
    if (halt_req !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL full_idle: halt_req=%b out_valid=%b required 0 0", halt_req, out_valid);
    end
  endtask

  task automatic test_halt_wait();
    load_rf();
    halted = 1'b0;
    do_start();
    for (int k = 0; k < 10; k++) begin
      total++;
      if (halt_req !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL halt_wait_c%0d: halt_req=%b out_valid=%b required 1 0", k, halt_req, out_valid);
      end
      tick();
    end
    halted = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL halt_rise_plus1: out_valid=%b required 0", out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_addr !== '0) begin
      bad++;
      $display("FAIL halt_rise_plus2: out_valid=%b addr=%0d required 1 0", out_valid, out_addr);
    end
    run_dump(0, 300);
    total++;
    if (timed_out || beat_addr.size() != NREGS || dones != 1) begin
      bad++;
      $display("FAIL halt_dump: beats=%0d dones=%0d timeout=%0d required %0d 1 0", beat_addr.size(), dones, timed_out, NREGS);
    end
  endtask

  task automatic test_backpressure(input int mode);
    load_rf();
    halted = 1'b1;
    do_start();
    run_dump(mode, 1000);
    total++;
    if (timed_out || beat_addr.size() != NREGS || hold_viol != 0) begin
      bad++;
      $display("FAIL bp%0d_stream: beats=%0d hold_violations=%0d timeout=%0d required %0d 0 0",
               mode, beat_addr.size(), hold_viol, timed_out, NREGS);
    end
    for (int i = 0; i < beat_addr.size() && i < NREGS; i++) begin
      total++;
      if (beat_addr[i] != i || beat_data[i] !== rf[i]) begin
        bad++;
        $display("FAIL bp%0d_beat%0d: addr=%0d data=%0d required addr=%0d data=%0d", mode, i, beat_addr[i], beat_data[i], i, rf[i]);
      end
    end
    total++;
    if (done_cyc != 1 + 2 * NREGS + stalls) begin
      bad++;
      $display("FAIL bp%0d_latency: done_at=%0d required %0d (stalls=%0d)", mode, done_cyc, 1 + 2 * NREGS + stalls, stalls);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit found = 0;
    load_rf();
    halted = 1'b1;
    out_ready = 1'b1;
    do_start();
    for (int k = 0; k < 100; k++) begin
      if (out_valid && out_addr == 7) begin
        found = 1;
        break;
      end
      tick();
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_reach: beat 7 seen=%0d required 1", found);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({out_valid, halt_req, busy, done} !== 4'b0000 || out_addr !== '0 || out_data !== '0 || rf_raddr !== '0) begin
      bad++;
      $display("FAIL reset_mid_state: ov=%b hr=%b busy=%b done=%b addr=%0d data=%0d required all 0",
               out_valid, halt_req, busy, done, out_addr, out_data);
    end
    do_start();
    run_dump(0, 300);
    total++;
    if (timed_out || beat_addr.size() != NREGS || beat_addr[0] != 0 || beat_data[0] !== rf[0]) begin
      bad++;
      $display("FAIL reset_restart: beats=%0d first_addr=%0d timeout=%0d required %0d 0 0",
               beat_addr.size(), (beat_addr.size() > 0) ? beat_addr[0] : -1, timed_out, NREGS);
    end
  endtask

  task automatic test_start_ignored();
    int n_done = 0;
    int n_beats = 0;
    load_rf();
    halted = 1'b1;
    out_ready = 1'b1;
    do_start();
    for (int k = 0; k < 200; k++) begin
      start = (k < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (out_valid && out_ready) n_beats++;
      tick();
      if (done) n_done++;
    end
    start = 1'b0;
    total++;
    if (n_done != 1 || n_beats != NREGS || busy !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored: dones=%0d beats=%0d busy=%b required 1 %0d 0", n_done, n_beats, busy, NREGS);
    end
  endtask

`ifdef REGFILE_DUMP_CHECK_EN
  task automatic test_check(input logic [DATA_W-1:0] expect_val);
    logic want;
    load_rf();
    halted = 1'b1;
    chk_addr = 5'd2;
    chk_expect = expect_val;
    want = (rf[2] == expect_val);
    do_start();
    chk_expect = ~expect_val;
    run_dump(2, 1000);
    total++;
    if (timed_out || chk_valid !== 1'b1 || chk_pass !== want) begin
      bad++;
      $display("FAIL chk_%0d: chk_valid=%b chk_pass=%b required 1 %b", expect_val, chk_valid, chk_pass, want);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_dump();
    test_halt_wait();
    test_backpressure(1);
    test_backpressure(2);
    test_reset_mid_dump();
    test_start_ignored();
    test_full_dump();
`ifdef REGFILE_DUMP_CHECK_EN
    test_check(32'd270);
    test_check(32'd58);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
